// File: rtl/pc_pkg.sv
`timescale 1ns/1ps
// pc_pkg
// Shared definitions for the program-counter stage: PC width, reset
// vector, step constant, the PC type and the next-PC source encoding
// together with the priority decoder that produces it.
package pc_pkg;

    localparam int PC_W = 8;
    localparam logic [PC_W-1:0] RESET_VECTOR = 8'h00;
    localparam logic [PC_W-1:0] PC_STEP      = 8'h01;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_CALL,
        SEL_RET,
        SEL_HOLD
    } next_pc_sel_t;

    // Fixed priority: stall, then ret, then call, then branch. Losing
    // requests are simply dropped by the caller.
    function automatic next_pc_sel_t decode_next_pc(
        input logic stall,
        input logic ret_en,
        input logic call_en,
        input logic branch_en
    );
        if (stall)          return SEL_HOLD;
        else if (ret_en)    return SEL_RET;
        else if (call_en)   return SEL_CALL;
        else if (branch_en) return SEL_BRANCH;
        else                return SEL_SEQ;
    endfunction

endpackage

// File: rtl/ras_stack.sv
`timescale 1ns/1ps
// ras_stack
// Small circular return-address stack.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, pop         request strobes (pop wins if both are high)
//   din               address to push
//   dout              current top entry (combinational read)
//   empty, full       decodes of the registered entry count
//   overflow          pulse: push while full (oldest entry overwritten)
//   underflow         pulse: pop while empty (nothing changes)
module ras_stack
    import pc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         overflow,
    output logic         underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PTR_W-1:0] top_reg;
    logic [PTR_W-1:0] top_inc;
    logic [PTR_W-1:0] top_dec;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    logic [DEPTH-1:0][W-1:0] entries;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_MAX);

    // DEPTH is a power of two, so the pointer wraps by plain overflow.
    assign top_inc = top_reg + 1'b1;
    assign top_dec = top_reg - 1'b1;

    assign do_pop    = pop && !empty;
    assign do_push   = push && !pop;
    assign underflow = pop && empty;
    assign overflow  = do_push && full;

    assign dout = entries[top_reg];

    // One register per entry; contents need no reset since count gates
    // every read that matters.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (do_push && (top_inc == PTR_W'(gi))) begin
                    entry_reg <= din;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            top_reg   <= '0;
            count_reg <= '0;
        end else if (do_pop) begin
            top_reg   <= top_dec;
            count_reg <= count_reg - 1'b1;
        end else if (do_push) begin
            top_reg <= top_inc;
            // When full, the write lands on the oldest slot and the
            // count saturates.
            if (!full) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// pc_sequencer
// 8-bit program-counter stage around an external combinational adder.
// The current pc and the step constant go out to the adder; its sum comes
// back as pc_sum and is the sequential next PC. Branch, call and return
// override it, with a circular return-address stack behind call/return.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   stall                         freeze pc, stack and flags this cycle
//   pc_sum                        adder result (pc + pc_step)
//   branch_en / branch_target     jump request
//   call_en / call_target         push pc_sum, jump to call_target
//   ret_en                        pop return address into pc
//   pc, pc_step                   adder operands; pc also feeds fetch
//   pc_valid                      low during and right after reset
//   ras_empty, ras_full           stack occupancy decodes
//   ras_err                       sticky overflow/underflow flag
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W         = pc_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_VECTOR = pc_pkg::RESET_VECTOR,
    parameter logic [PC_W-1:0] PC_STEP      = pc_pkg::PC_STEP,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [PC_W-1:0] pc_sum,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_target,
    input  logic            call_en,
    input  logic [PC_W-1:0] call_target,
    input  logic            ret_en,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_step,
    output logic            pc_valid,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_err
);

    next_pc_sel_t    sel;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;
    logic            pc_valid_reg;
    logic            ras_err_reg;
    logic [PC_W-1:0] ras_dout;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_overflow;
    logic            ras_underflow;

    assign sel      = decode_next_pc(stall, ret_en, call_en, branch_en);
    assign ras_push = (sel == SEL_CALL);
    assign ras_pop  = (sel == SEL_RET);

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .din       (pc_sum),
        .dout      (ras_dout),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    always_comb begin
        pc_next = pc_sum;
        case (sel)
            SEL_HOLD:   pc_next = pc_reg;
            // A return on an empty stack falls through sequentially.
            SEL_RET:    pc_next = ras_empty ? pc_sum : ras_dout;
            SEL_CALL:   pc_next = call_target;
            SEL_BRANCH: pc_next = branch_target;
            default:    pc_next = pc_sum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg       <= RESET_VECTOR;
            pc_valid_reg <= 1'b0;
            ras_err_reg  <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            pc_valid_reg <= 1'b1;
            // The stack only pulses these when a request was accepted,
            // so a stall can never set the flag.
            if (ras_overflow || ras_underflow) begin
                ras_err_reg <= 1'b1;
            end
        end
    end

    assign pc       = pc_reg;
    assign pc_step  = PC_STEP;
    assign pc_valid = pc_valid_reg;
    assign ras_err  = ras_err_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] pc_sum;
    logic       branch_en = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       call_en = 1'b0;
    logic [7:0] call_target = 8'h00;
    logic       ret_en = 1'b0;
    logic [7:0] pc;
    logic [7:0] pc_step;
    logic       pc_valid;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_err;

    always #5 clk = ~clk;

    // Combinational adder of the datapath.
    assign pc_sum = pc + pc_step;

    pc_sequencer #(.RAS_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_sum        (pc_sum),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .call_en       (call_en),
        .call_target   (call_target),
        .ret_en        (ret_en),
        .pc            (pc),
        .pc_step       (pc_step),
        .pc_valid      (pc_valid),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    typedef struct {
        string      tag;
        logic [7:0] pc;
        logic       valid;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [7:0] m_pc;
    logic       m_valid;
    logic       m_err;
    logic [7:0] m_stack[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock transaction: drive at negedge, predict, sample after edge.
    task automatic step(input string tag, input logic rst_v, input logic st_v,
                        input logic ret_v, input logic call_v, input logic br_v,
                        input logic [7:0] bt, input logic [7:0] ct);
        logic [7:0] sum;
        logic [7:0] junk;
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n = rst_v; stall = st_v; ret_en = ret_v; call_en = call_v;
        branch_en = br_v; branch_target = bt; call_target = ct;
        if (!rst_v) begin
            m_pc = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_stack.delete();
        end else begin
            m_valid = 1'b1;
            if (!st_v) begin
                sum = m_pc + 8'h01;
                if (ret_v) begin
                    if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin m_pc = sum; m_err = 1'b1; end
                end else if (call_v) begin
                    m_stack.push_back(sum);
                    if (m_stack.size() > DEPTH) begin
                        junk = m_stack.pop_front();
                        m_err = 1'b1;
                    end
                    m_pc = ct;
                end else if (br_v) begin
                    m_pc = bt;
                end else begin
                    m_pc = sum;
                end
            end
        end
        e.tag = tag; e.pc = m_pc; e.valid = m_valid; e.err = m_err;
        e.empty = (m_stack.size() == 0);
        e.full = (m_stack.size() == DEPTH);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({got.tag, "_pc"}, 32'(pc), 32'(got.pc));
        check({got.tag, "_valid"}, 32'(pc_valid), 32'(got.valid));
        check({got.tag, "_empty"}, 32'(ras_empty), 32'(got.empty));
        check({got.tag, "_full"}, 32'(ras_full), 32'(got.full));
        check({got.tag, "_err"}, 32'(ras_err), 32'(got.err));
        $display("[%0t] %-8s pc=%02h valid=%0b empty=%0b full=%0b err=%0b",
                 $time, got.tag, pc, pc_valid, ras_empty, ras_full, ras_err);
    endtask

    task automatic seq(input string tag);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic branch(input string tag, input logic [7:0] t);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, t, 8'h00);
    endtask

    task automatic call(input string tag, input logic [7:0] t);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, t);
    endtask

    task automatic ret(input string tag);
        step(tag, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic reset(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        // Reset and release
        reset("rst0");
        reset("rst1");
        check("pc_step", 32'(pc_step), 32'h01);
        check("rst_pc", 32'(pc), 32'h00);
        for (int i = 0; i < 3; i++) seq("seq");
        check("seq_pc3", 32'(pc), 32'h03);

        // Wrap through FF
        branch("br_fe", 8'hFE);
        for (int i = 0; i < 3; i++) seq("wrap");
        check("wrap_pc", 32'(pc), 32'h01);

        // Single call / return
        branch("br_10", 8'h10);
        call("call40", 8'h40);
        seq("sub");
        seq("sub");
        ret("ret");
        check("ret_pc", 32'(pc), 32'h11);
        check("ret_empty", 32'(ras_empty), 32'h1);

        // Nested calls beyond depth, then unwind past empty
        reset("rst2");
        call("n_call1", 8'h40);
        call("n_call2", 8'h50);
        call("n_call3", 8'h60);
        call("n_call4", 8'h70);
        check("full4", 32'(ras_full), 32'h1);
        check("noerr4", 32'(ras_err), 32'h0);
        call("n_call5", 8'h80);
        check("ovf_err", 32'(ras_err), 32'h1);
        ret("n_ret1");
        check("n_ret1_pc", 32'(pc), 32'h71);
        ret("n_ret2");
        ret("n_ret3");
        ret("n_ret4");
        check("n_ret4_pc", 32'(pc), 32'h41);
        ret("n_ret5");
        check("udf_pc", 32'(pc), 32'h42);

        // Stall with a branch held high: branch is dropped
        for (int i = 0; i < 3; i++)
            step("stall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 8'h00);
        check("stall_pc", 32'(pc), 32'h42);
        seq("post_st");
        check("post_st_pc", 32'(pc), 32'h43);

        // Simultaneous ret/call/branch with 22 on the stack
        branch("br_21", 8'h21);
        call("call30", 8'h30);
        step("all3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h50, 8'h60);
        check("all3_pc", 32'(pc), 32'h22);
        check("all3_empty", 32'(ras_empty), 32'h1);

        // Mid-sequence reset discards stack and error flag
        call("call70", 8'h70);
        seq("seq");
        reset("rst3");
        check("rst3_pc", 32'(pc), 32'h00);
        check("rst3_err", 32'(ras_err), 32'h0);
        check("rst3_empty", 32'(ras_empty), 32'h1);
        seq("rel");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- 8-bit program-counter stage wrapped around the datapath's combinational 8-bit adder.
- Drives the current PC and the step constant into the adder, takes back the adder's sum as the sequential next PC, and selects the actual next PC.
- Next-PC sources: sequential, branch, call, return. Includes stall control and a small circular return-address stack (RAS).

Parameters:
- PC_W, 8, PC/address width; must match the adder width.
- RESET_VECTOR, 8'h00, PC value loaded on reset.
- PC_STEP, 8'h01, increment presented to the adder.
- RAS_DEPTH, 4, return-address stack entries (power of 2, 2..16).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- stall  in  1  hold all state this cycle.
- pc_sum  in  8  adder Sum (pc + step), sampled same cycle.
- branch_en  in  1  take branch_target.
- branch_target  in  8  branch destination.
- call_en  in  1  push return address, jump to call_target.
- call_target  in  8  call destination.
- ret_en  in  1  pop return address into PC.
- pc  out  8  current PC; feeds adder Input1 and instruction fetch.
- pc_step  out  8  constant PC_STEP; feeds adder Input2.
- pc_valid  out  1  PC is meaningful (low during and right after reset).
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset is sampled only at the clk edge. On an edge with rst_n=0:
  - pc=RESET_VECTOR, pc_valid=0, stack top=0, count=0, ras_err=0.
  - Stack contents are don't-care.
  - ras_empty=1, ras_full=0.
- Reset overrides every other input, including a call/ret in the same cycle. Mid-operation reset discards the stack.
- pc_valid goes to 1 on the first edge with rst_n=1 and then stays 1.
- pc_step is a continuous constant; it is not reset-dependent.
- The adder is combinational. pc_sum is the adder result for the current pc and is consumed in the same cycle. The new pc is visible 1 cycle after the request edge.
- Next-PC priority, evaluated each edge with rst_n=1:
  1. stall=1: pc, stack, count and flags all hold. branch/call/ret are ignored, not queued.
  2. ret_en=1, count>0: pc=stack[top]; top=top-1 mod RAS_DEPTH; count-1.
  3. ret_en=1, count=0: underflow. pc=pc_sum (fall-through), ras_err<=1.
  4. call_en=1: top=top+1 mod RAS_DEPTH; stack[new top]=pc_sum; pc=call_target.
     - count<RAS_DEPTH: count+1.
     - count=RAS_DEPTH: oldest entry is silently overwritten (circular), count stays, ras_err<=1.
  5. branch_en=1: pc=branch_target; stack untouched.
  6. Otherwise: pc=pc_sum.
- Simultaneous requests: ret beats call beats branch; losers are dropped. A dropped call performs no push.
- Wrap-around:
  - pc=8'hFF with step 1 gives pc_sum=8'h00, taken without any flag.
  - Stack pointer wraps modulo RAS_DEPTH.
- ras_err clears only by reset.
- ras_empty/ras_full are combinational decodes of the registered count.
- While pc_valid=0, requests are still honoured per the rules above. The fetch side ignores pc.

Decomposition:
- Shared package pc_pkg holds:
  - PC_W, RESET_VECTOR, PC_STEP.
  - Typedef pc_t (logic [PC_W-1:0]).
  - Enum next_pc_sel_t {SEL_SEQ, SEL_BRANCH, SEL_CALL, SEL_RET, SEL_HOLD}, produced by the priority decoder.
- One natural sub-module, ras_stack:
  - Inputs: push, pop, din.
  - Outputs: dout (top entry), empty, full, overflow/underflow pulses.
  - Holds the storage array, top pointer and count, with synchronous active-low reset.
- pc_sequencer holds the decoder, pc register, pc_valid and sticky ras_err.

Test Plan:
- Reset, then release with no requests (adder model 8-bit +1) -> pc_valid=0 until the first release edge; pc sequence 00,01,02,03; pc_step=01.
- pc=8'hFE, no requests -> FE, FF, 00, 01; no flags.
- At pc=10, call_en with call_target=40; then 2 sequential cycles; then ret_en -> pc goes 40,41,42, then 11. Stack ends empty.
- 5 nested calls from pc=00,40,50,60,70 (RAS_DEPTH=4), then 5 rets -> full asserted after the 4th call; ras_err=1 after the 5th. Rets return 71,61,51,41. 5th ret underflows: pc takes pc_sum, ras_err stays 1.
- stall=1 for 3 cycles with branch_en (target 80) asserted during the stall -> pc frozen; after the stall pc increments normally (branch dropped).
- Same-cycle ret_en, call_en, branch_en with stack holding 22 -> pc=22, no push. Then rst_n=0 mid-sequence -> pc=00, ras_empty=1, ras_err=0 on the next edge.
